// File: rtl/parking_gate_scheduler.sv
// Shared barrier-gate sequencer for a 4-spot car park: round-robin entry/exit
// arbitration, spot allocation/release, and timed gate-open / lot-full windows.
module parking_gate_scheduler #(
    parameter int NUM_SPOTS   = 4,
    parameter int OPEN_CYCLES = 50,
    parameter int FULL_CYCLES = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [1:0] exit_spot,
    output logic       gate_open,
    output logic       full_flag,
    output logic       grant_entry,
    output logic       grant_exit,
    output logic [3:0] spots,
    output logic [2:0] free_count,
    output logic [1:0] assigned_spot,
    output logic       assign_valid,
    output logic       exit_err,
    output logic [2:0] state
);
    localparam int MAX_CYCLES = (OPEN_CYCLES > FULL_CYCLES) ? OPEN_CYCLES : FULL_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ALLOC     = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_OPEN      = 3'd3,
        ST_FULL_HOLD = 3'd4
    } state_e;

    function automatic logic [1:0] lowest_free(input logic [3:0] occ);
        logic [1:0] idx;
        casez (occ)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       spots_q, spots_d;
    logic [2:0]       free_q, free_d;
    logic [1:0]       assigned_q, assigned_d;
    logic [1:0]       exit_spot_q, exit_spot_d;
    logic             assign_valid_q, assign_valid_d;
    logic             exit_err_q, exit_err_d;
    logic             gate_q, gate_d;
    logic             full_q, full_d;
    logic             grant_entry_q, grant_entry_d;
    logic             grant_exit_q, grant_exit_d;
    logic             rr_exit_q, rr_exit_d;
    logic             entry_armed_q, entry_armed_d;
    logic             exit_armed_q, exit_armed_d;
    logic             entry_go_s, exit_go_s;
    logic [1:0]       alloc_idx_s;

    assign entry_go_s  = entry_armed_q & entry_req;
    assign exit_go_s   = exit_armed_q & exit_req;
    assign alloc_idx_s = lowest_free(spots_q);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        spots_d        = spots_q;
        free_d         = free_q;
        assigned_d     = assigned_q;
        exit_spot_d    = exit_spot_q;
        assign_valid_d = 1'b0;
        exit_err_d     = 1'b0;
        gate_d         = gate_q;
        full_d         = full_q;
        grant_entry_d  = grant_entry_q;
        grant_exit_d   = grant_exit_q;
        rr_exit_d      = rr_exit_q;
        // A low sample re-arms a lane; a grant below overrides this.
        entry_armed_d  = entry_req ? entry_armed_q : 1'b1;
        exit_armed_d   = exit_req  ? exit_armed_q  : 1'b1;

        case (state_q)
            ST_IDLE: begin
                gate_d        = 1'b0;
                full_d        = 1'b0;
                grant_entry_d = 1'b0;
                grant_exit_d  = 1'b0;
                cnt_d         = '0;
                if ((entry_go_s && exit_go_s && rr_exit_q) || (exit_go_s && !entry_go_s)) begin
                    state_d      = ST_RELEASE;
                    exit_spot_d  = exit_spot;
                    exit_armed_d = 1'b0;
                end else if (entry_go_s) begin
                    state_d       = ST_ALLOC;
                    entry_armed_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
                if (entry_go_s && exit_go_s) begin
                    rr_exit_d = ~rr_exit_q;
                end else begin
                    rr_exit_d = rr_exit_q;
                end
            end
            ST_ALLOC: begin
                cnt_d = '0;
                if (free_q == 3'd0) begin
                    state_d = ST_FULL_HOLD;
                    full_d  = 1'b1;
                end else begin
                    state_d        = ST_OPEN;
                    spots_d        = spots_q | (4'b0001 << alloc_idx_s);
                    free_d         = free_q - 3'd1;
                    assigned_d     = alloc_idx_s;
                    assign_valid_d = 1'b1;
                    grant_entry_d  = 1'b1;
                    gate_d         = 1'b1;
                end
            end
            ST_RELEASE: begin
                cnt_d = '0;
                if (spots_q[exit_spot_q]) begin
                    state_d      = ST_OPEN;
                    spots_d      = spots_q & ~(4'b0001 << exit_spot_q);
                    free_d       = free_q + 3'd1;
                    grant_exit_d = 1'b1;
                    gate_d       = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                    exit_err_d = 1'b1;
                end
            end
            ST_OPEN: begin
                if (cnt_q == CNT_W'(OPEN_CYCLES - 1)) begin
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    gate_d        = 1'b0;
                    grant_entry_d = 1'b0;
                    grant_exit_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FULL_HOLD: begin
                if (cnt_q == CNT_W'(FULL_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    full_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d       = ST_IDLE;
                cnt_d         = '0;
                gate_d        = 1'b0;
                full_d        = 1'b0;
                grant_entry_d = 1'b0;
                grant_exit_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            spots_q        <= 4'b0000;
            free_q         <= 3'(NUM_SPOTS);
            assigned_q     <= 2'd0;
            exit_spot_q    <= 2'd0;
            assign_valid_q <= 1'b0;
            exit_err_q     <= 1'b0;
            gate_q         <= 1'b0;
            full_q         <= 1'b0;
            grant_entry_q  <= 1'b0;
            grant_exit_q   <= 1'b0;
            rr_exit_q      <= 1'b1;
            entry_armed_q  <= 1'b1;
            exit_armed_q   <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            spots_q        <= spots_d;
            free_q         <= free_d;
            assigned_q     <= assigned_d;
            exit_spot_q    <= exit_spot_d;
            assign_valid_q <= assign_valid_d;
            exit_err_q     <= exit_err_d;
            gate_q         <= gate_d;
            full_q         <= full_d;
            grant_entry_q  <= grant_entry_d;
            grant_exit_q   <= grant_exit_d;
            rr_exit_q      <= rr_exit_d;
            entry_armed_q  <= entry_armed_d;
            exit_armed_q   <= exit_armed_d;
        end
    end

    assign gate_open     = gate_q;
    assign full_flag     = full_q;
    assign grant_entry   = grant_entry_q;
    assign grant_exit    = grant_exit_q;
    assign spots         = spots_q;
    assign free_count    = free_q;
    assign assigned_spot = assigned_q;
    assign assign_valid  = assign_valid_q;
    assign exit_err      = exit_err_q;
    assign state         = state_q;
endmodule

// File: doc/parking_gate_scheduler.md
Name: parking_gate_scheduler

Overview:
- Sequences the single shared barrier gate of the 4-spot car park between the entry lane and the exit lane.
- Arbitrates between simultaneous entry and exit requests with round-robin fairness.
- Allocates and releases spots and maintains the occupancy map and free count.
- Times the gate-open and full-indication windows.
- Sits between the lane sensors and the light/divider drivers; the light drivers consume gate_open and full_flag.

Parameters:
NUM_SPOTS, 4, number of parking spots (fixed at 4 for this revision)
OPEN_CYCLES, 50, clock cycles gate_open stays high per grant
FULL_CYCLES, 14, clock cycles full_flag stays high per rejected entry

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
entry_req  input  1  entry sensor level
exit_req  input  1  exit sensor level
exit_spot  input  2  spot index of the departing car, sampled when exit is granted
gate_open  output  1  barrier open command
full_flag  output  1  entry rejected, lot full
grant_entry  output  1  current gate cycle serves the entry lane
grant_exit  output  1  current gate cycle serves the exit lane
spots  output  4  occupancy map; bit i = spot i occupied
free_count  output  3  free spots, 0..4
assigned_spot  output  2  spot given to the last admitted car
assign_valid  output  1  one-cycle pulse when assigned_spot updates
exit_err  output  1  one-cycle pulse: exit named an empty spot
state  output  3  FSM state, for debug

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE(0); spots=0; free_count=4; assigned_spot=0.
  - All pulses, grants, gate_open and full_flag = 0.
  - Round-robin pointer prefers exit; both lanes armed.
  - Reset mid-OPEN or mid-FULL_HOLD drops gate_open/full_flag immediately, with no pending completion.
- States: IDLE=0, ALLOC=1, RELEASE=2, OPEN=3, FULL_HOLD=4. All outputs are registered.
- Arming:
  - A lane is armed while its request has been low for at least one cycle since it was last served.
  - A request held high is served once only.
  - A lane is disarmed when it is granted (leaves IDLE).
- IDLE:
  - Only entry armed and high -> ALLOC.
  - Only exit armed and high -> RELEASE, latching exit_spot.
  - Both -> lane chosen by the pointer; pointer flips to the other lane after every contested grant.
  - Uncontested grants leave the pointer unchanged.
- ALLOC:
  - If free_count==0 -> FULL_HOLD, with no change to spots or count.
  - Otherwise:
    - Select the lowest-index clear bit of spots and set it; free_count-1.
    - assigned_spot=that index; assign_valid=1 for one cycle.
    - grant_entry=1 -> OPEN.
- RELEASE:
  - If spots[latched exit_spot]==0: exit_err=1 for one cycle -> IDLE; no gate, no count change.
  - Otherwise: clear the bit; free_count+1; grant_exit=1 -> OPEN.
- OPEN:
  - gate_open=1 for exactly OPEN_CYCLES consecutive cycles, starting the cycle after ALLOC/RELEASE.
  - The grant bit is held for the same window.
  - Then both clear and state -> IDLE.
  - Requests arriving during OPEN wait; they are evaluated in IDLE.
- FULL_HOLD:
  - full_flag=1 for exactly FULL_CYCLES cycles, then -> IDLE.
  - gate_open stays 0.
- Latency: request high in IDLE at edge k -> ALLOC/RELEASE after edge k -> gate_open high after edge k+1.
- Invariants:
  - free_count == NUM_SPOTS - popcount(spots) at all times.
  - free_count never exceeds 4 or wraps below 0.
  - grant_entry and grant_exit are never both 1.
  - gate_open and full_flag are never both 1.
- Counter: width ceil(log2(max(OPEN_CYCLES,FULL_CYCLES)))+1; cleared on every state entry.

Test Plan:
1. Reset, then 4 entry pulses spaced beyond OPEN_CYCLES:
   - assigned_spot = 0,1,2,3 in order; spots=1111; free_count=0.
   - Each gate_open window is exactly 50 cycles.
2. With lot full, entry pulse:
   - full_flag high exactly 14 cycles; gate_open=0; spots and count unchanged.
3. Full lot, exit_req with exit_spot=1:
   - grant_exit and gate_open for 50 cycles; spots=1101; free_count=1.
   - Next entry gets assigned_spot=1.
4. Entry and exit asserted on the same cycle, twice, with spots=0011:
   - First contest serves exit (pointer reset value); second contest serves entry.
   - Grants are never simultaneous.
5. Exit with exit_spot=2 while spots[2]=0:
   - exit_err one-cycle pulse; state returns to IDLE; no gate; free_count unchanged.
6. entry_req held high for 200 cycles:
   - Exactly one allocation.
   - Assert reset=0 mid-OPEN: gate_open drops asynchronously; state=0; spots=0; free_count=4.
